tlc_receiver: RTL and testbench

TLC_RECEIVER -- requirements
Module: tlc_receiver

---
 rtl/tlc_receiver.sv | 145 ++++++++++++++
 tb/tb_tlc_receiver.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_receiver
//  Purpose  : Receiver model of a serial grayscale/dot-correction LED driver.
//             Captures the led_* serial bus with rising-edge detection, latches
//             grayscale or dot-correction words on xlat, and produces
//             per-channel PWM from a saturating grayscale counter.
//  Options  : TLC_RECEIVER_SOUT_EN - enables the registered daisy-chain output.
//             Without it, sout is tied to 0 and no extra register exists.
//  Revision : 1.0 - initial release
// ============================================================================
module tlc_receiver #(
  parameter int CHANNELS = 16,
  parameter int GS_BITS  = 12,
  parameter int DC_BITS  = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          led_sclk,
  input  logic                          led_sin,
  input  logic                          led_xlat,
  input  logic                          led_mode,
  input  logic                          led_blank,
  input  logic                          led_gsclk,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic [CHANNELS*GS_BITS-1:0]   gs_data,
  output logic [CHANNELS*DC_BITS-1:0]   dc_data,
  output logic [GS_BITS-1:0]            gs_count,
  output logic [7:0]                    latch_count,
  output logic                          sout
);

  localparam int                 c_sr_bits = CHANNELS * GS_BITS;
  localparam int                 c_dc_bits = CHANNELS * DC_BITS;
  localparam logic [GS_BITS-1:0] c_gs_max  = '1;

  logic                    r_sclk_prev;
  logic                    r_xlat_prev;
  logic                    r_gsclk_prev;
  logic                    r_armed;
  logic [c_sr_bits-1:0]    r_shift;
  logic [c_sr_bits-1:0]    r_gs;
  logic [c_dc_bits-1:0]    r_dc;
  logic [GS_BITS-1:0]      r_gs_count;
  logic [CHANNELS-1:0]     r_pwm;
  logic [7:0]              r_latch_count;

  logic                    w_sclk_rise;
  logic                    w_xlat_rise;
  logic                    w_gsclk_rise;
  logic [CHANNELS-1:0]     w_below;

  // r_armed masks the first cycle after reset: the previous-value registers
  // were forced to 0 then, so a line already high is not mistaken for an edge.
  assign w_sclk_rise  = r_armed & led_sclk  & ~r_sclk_prev;
  assign w_xlat_rise  = r_armed & led_xlat  & ~r_xlat_prev;
  assign w_gsclk_rise = r_armed & led_gsclk & ~r_gsclk_prev;

  // Single-stage history of the bus strobes for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sclk_prev  <= 1'b0;
      r_xlat_prev  <= 1'b0;
      r_gsclk_prev <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_sclk_prev  <= led_sclk;
      r_xlat_prev  <= led_xlat;
      r_gsclk_prev <= led_gsclk;
      r_armed      <= 1'b1;
    end
  end

  // Serial input shift register, MSB first; oldest bits fall off the top.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
    end else if (w_sclk_rise) begin
      r_shift <= {r_shift[c_sr_bits-2:0], led_sin};
    end
  end

  // Latch on xlat; reads the pre-shift contents even with a concurrent sclk.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gs          <= '0;
      r_dc          <= '0;
      r_latch_count <= 8'd0;
    end else if (w_xlat_rise) begin
      if (led_mode) begin
        r_dc <= r_shift[c_dc_bits-1:0];
      end else begin
        r_gs <= r_shift;
      end
      r_latch_count <= r_latch_count + 8'd1;
    end
  end

  // Grayscale counter: cleared by blank, saturates at full scale.
  always_ff @(posedge clock) begin
    if (reset || led_blank) begin
      r_gs_count <= '0;
    end else if (w_gsclk_rise && (r_gs_count != c_gs_max)) begin
      r_gs_count <= r_gs_count + GS_BITS'(1);
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_pwm_cmp
    assign w_below[n] = (r_gs_count < r_gs[n*GS_BITS +: GS_BITS]);
  end

  // PWM outputs trail the counter by one clock and are forced off by blank.
  always_ff @(posedge clock) begin
    if (reset || led_blank) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_below;
    end
  end

`ifdef TLC_RECEIVER_SOUT_EN
  logic r_sout;

  // Daisy-chain output: the bit pushed out of the top by each sclk edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sout <= 1'b0;
    end else if (w_sclk_rise) begin
      r_sout <= r_shift[c_sr_bits-1];
    end
  end

  assign sout = r_sout;
`else
  assign sout = 1'b0;
`endif

  assign pwm_out     = r_pwm;
  assign gs_data     = r_gs;
  assign dc_data     = r_dc;
  assign gs_count    = r_gs_count;
  assign latch_count = r_latch_count;

endmodule
`default_nettype wire

// File: tb/tb_tlc_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlc_receiver
//  Purpose  : Self-checking bench for tlc_receiver using a scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tlc_receiver;

  localparam int CHANNELS = 16;
  localparam int GS_BITS  = 12;
  localparam int DC_BITS  = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        led_sclk = 1'b0, led_sin = 1'b0, led_xlat = 1'b0;
  logic        led_mode = 1'b0, led_blank = 1'b0, led_gsclk = 1'b0;
  logic [15:0]  pwm_out;
  logic [191:0] gs_data;
  logic [95:0]  dc_data;
  logic [11:0]  gs_count;
  logic [7:0]   latch_count;
  logic         sout;

  tlc_receiver #(.CHANNELS(CHANNELS), .GS_BITS(GS_BITS), .DC_BITS(DC_BITS)) dut (
    .clock(clock), .reset(reset),
    .led_sclk(led_sclk), .led_sin(led_sin), .led_xlat(led_xlat),
    .led_mode(led_mode), .led_blank(led_blank), .led_gsclk(led_gsclk),
    .pwm_out(pwm_out), .gs_data(gs_data), .dc_data(dc_data),
    .gs_count(gs_count), .latch_count(latch_count), .sout(sout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string        tag;
    logic [191:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];

  // Reference model state
  logic [191:0] m_shift = '0;
  logic [191:0] m_gs    = '0;
  logic [95:0]  m_dc    = '0;
  logic [7:0]   m_latch = '0;
  logic         m_sout  = 1'b0;
  int           m_cnt   = 0;

  task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [191:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop_check(input logic [191:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", obs, ~obs);
    end else begin
      it = sb_q.pop_front();
      check_val(it.tag, obs, it.val);
    end
  endtask

  function automatic logic [15:0] exp_pwm(input int cnt);
    logic [15:0] r;
    for (int ch = 0; ch < CHANNELS; ch++)
      r[ch] = (cnt < int'(m_gs[ch*GS_BITS +: GS_BITS]));
    return r;
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    {led_sclk, led_sin, led_xlat, led_mode, led_blank, led_gsclk} = '0;
    m_shift = '0; m_gs = '0; m_dc = '0; m_latch = '0; m_sout = 1'b0; m_cnt = 0;
    sb_push("rst_gs_data", '0);
    sb_push("rst_dc_data", '0);
    sb_push("rst_gs_count", '0);
    sb_push("rst_pwm_out", '0);
    sb_push("rst_latch_count", '0);
    sb_push("rst_sout", '0);
    repeat (3) @(negedge clock);
    sb_pop_check(gs_data);
    sb_pop_check(dc_data);
    sb_pop_check(gs_count);
    sb_pop_check(pwm_out);
    sb_pop_check(latch_count);
    sb_pop_check(sout);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic sclk_bit(input logic b);
`ifdef TLC_RECEIVER_SOUT_EN
    m_sout = m_shift[191];
`endif
    m_shift = {m_shift[190:0], b};
    led_sin  = b;
    led_sclk = 1'b1;
    @(negedge clock);
    led_sclk = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_bits(input logic [191:0] f, input int nbits, input string tag);
    for (int i = nbits - 1; i >= 0; i--) sclk_bit(f[i]);
    sb_push(tag, {191'd0, m_sout});
    sb_pop_check(sout);
  endtask

  // Latch pulse; with_sclk also shifts led_sin=1 in the same cycle.
  task automatic xlat_pulse(input logic mode, input logic with_sclk, input string tag);
    if (mode) m_dc = m_shift[95:0];
    else      m_gs = m_shift;
    m_latch = m_latch + 8'd1;
    sb_push({tag, "_gs_data"}, m_gs);
    sb_push({tag, "_dc_data"}, {96'd0, m_dc});
    sb_push({tag, "_latch_count"}, {184'd0, m_latch});
    if (with_sclk) begin
`ifdef TLC_RECEIVER_SOUT_EN
      m_sout = m_shift[191];
`endif
      m_shift = {m_shift[190:0], 1'b1};
    end
    led_mode = mode;
    led_sin  = 1'b1;
    led_xlat = 1'b1;
    led_sclk = with_sclk;
    @(negedge clock);
    led_xlat = 1'b0;
    led_sclk = 1'b0;
    @(negedge clock);
    sb_pop_check(gs_data);
    sb_pop_check(dc_data);
    sb_pop_check(latch_count);
  endtask

  task automatic gsclk_pulse();
    m_cnt = (m_cnt == 4095) ? 4095 : m_cnt + 1;
    sb_push("pwm_gs_count", m_cnt);
    sb_push("pwm_pwm_out", {176'd0, exp_pwm(m_cnt)});
    led_gsclk = 1'b1;
    @(negedge clock);
    led_gsclk = 1'b0;
    @(negedge clock);
    sb_pop_check(gs_count);
    sb_pop_check(pwm_out);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [191:0] frame;
    logic [95:0]  dc_pat;
    logic [5:0]   dc_word;
    int           pwm0_high;
    int           pwm15_low;

    // Reset values
    reset_dut();

    // Dot-correction load: 16 channels of value 3
    dc_word = 6'b000011;
    dc_pat  = {16{dc_word}};
    send_bits({96'd0, dc_pat}, 96, "dc_sout");
    xlat_pulse(1'b1, 1'b0, "dc_load");

    // sclk and xlat together: latch sees pre-shift data, shift still happens
    frame = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_bits(frame, 192, "coinc_sout");
    xlat_pulse(1'b0, 1'b1, "coinc_latch");
    xlat_pulse(1'b0, 1'b0, "coinc_after");

    // Reset partway through a frame, then a complete fresh frame
    frame = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 191; i > 91; i--) sclk_bit(frame[i]);
    reset_dut();
    frame = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_bits(frame, 192, "abort_sout");
    xlat_pulse(1'b0, 1'b0, "abort_frame");

    // Grayscale frame: channel 15 full scale, channel 0 = 1
    frame = '0;
    frame[191:180] = 12'hFFF;
    frame[11:0]    = 12'h001;
    send_bits(frame, 192, "gs_sout");
    xlat_pulse(1'b0, 1'b0, "gs_load");
    sb_push("gs_ch15", 192'hFFF);
    sb_push("gs_ch0", 192'h001);
    sb_pop_check(gs_data[191:180]);
    sb_pop_check(gs_data[11:0]);

    // Blank holds counter and PWM at zero
    led_blank = 1'b1;
    repeat (2) @(negedge clock);
    m_cnt = 0;
    sb_push("blank_gs_count", '0);
    sb_push("blank_pwm_out", '0);
    sb_pop_check(gs_count);
    sb_pop_check(pwm_out);

    // Full PWM sweep past saturation
    led_blank = 1'b0;
    @(negedge clock);
    sb_push("pwm_start", {176'd0, exp_pwm(0)});
    sb_pop_check(pwm_out);
    pwm0_high = pwm_out[0] ? 1 : 0;
    pwm15_low = pwm_out[15] ? 0 : 1;
    for (int k = 0; k < 4100; k++) begin
      gsclk_pulse();
      if (pwm_out[0])   pwm0_high++;
      if (!pwm_out[15]) pwm15_low++;
    end
    check_val("pwm0_high_counts", pwm0_high, 1);
    check_val("pwm15_low_counts", pwm15_low, 6);
    check_val("gs_count_saturated", gs_count, 4095);

    // Blank in mid-run clears on the next clock
    led_blank = 1'b1;
    @(negedge clock);
    m_cnt = 0;
    sb_push("reblank_gs_count", '0);
    sb_push("reblank_pwm_out", '0);
    sb_pop_check(gs_count);
    sb_pop_check(pwm_out);
    led_blank = 1'b0;
    @(negedge clock);

    // Grayscale update mid-PWM takes effect without restarting the counter
    for (int k = 0; k < 10; k++) gsclk_pulse();
    frame = '0;
    frame[11:0]    = 12'd20;
    frame[191:180] = 12'd5;
    send_bits(frame, 192, "mid_sout");
    xlat_pulse(1'b0, 1'b0, "mid_load");
    sb_push("mid_gs_count", 10);
    sb_push("mid_pwm_out", {176'd0, exp_pwm(10)});
    sb_pop_check(gs_count);
    sb_pop_check(pwm_out);

`ifdef TLC_RECEIVER_SOUT_EN
    // Daisy chain: a leading 1 emerges on the 193rd sclk edge
    reset_dut();
    sclk_bit(1'b1);
    sb_push("sout_edge_first", '0);
    sb_pop_check(sout);
    for (int i = 0; i < 191; i++) sclk_bit(1'b0);
    sb_push("sout_edge_192nd", '0);
    sb_pop_check(sout);
    sclk_bit(1'b0);
    sb_push("sout_edge_193rd", 192'd1);
    sb_pop_check(sout);
`endif

    if (sb_q.size() != 0) check_val("scoreboard_leftover", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
